snoop_bus_arbiter: RTL

- Arbitrates the shared snoopy bus between N_REQ per-processor cache_coherence controllers.
- Sequences each granted transaction through address broadcast, snoop collection, memory read, invalidate collection or dirty-abort write-back.
- Generates the READ_DONE, send_abort, AllInvDone and shared/exclusive indications that the controllers consume.

---
 rtl/snoop_bus_pkg.sv | 24 ++
 rtl/snoop_bus_arbiter_if.sv | 35 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/snoop_bus_arbiter.sv | 132 +++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared encodings for the snoopy bus: transaction ops, sequencer states and
// the sizing helper for the memory read counter.
package snoop_bus_pkg;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WMISS   = 2'b01;
  localparam logic [1:0] OP_UPGRADE = 2'b10;
  localparam logic [1:0] OP_RSVD    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    SNOOP = 3'd2,
    DATA  = 3'd3,
    INV   = 3'd4,
    WB    = 3'd5,
    DONE  = 3'd6
  } state_t;

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// Snoopy bus bundle between the arbiter (master) and the cache controllers
// (slave): requests, broadcast, snoop responses and completion indications.
interface snoop_bus_arbiter_if #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 8
);
  logic [N_REQ-1:0]        req;
  logic [2*N_REQ-1:0]      req_op;
  logic [ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]        grant;
  logic                    bus_valid;
  logic [1:0]              bus_op;
  logic [ADDR_W-1:0]       bus_addr;
  logic [N_REQ-1:0]        snoop_shr;
  logic [N_REQ-1:0]        snoop_mod;
  logic [N_REQ-1:0]        inv_ack;
  logic                    write_back_done;
  logic                    read_done;
  logic                    read_shared;
  logic                    send_abort;
  logic                    all_inv_done;
  logic                    done;

  modport master (
    input  req, req_op, req_addr, snoop_shr, snoop_mod, inv_ack, write_back_done,
    output grant, bus_valid, bus_op, bus_addr, read_done, read_shared,
           send_abort, all_inv_done, done
  );

  modport slave (
    output req, req_op, req_addr, snoop_shr, snoop_mod, inv_ack, write_back_done,
    input  grant, bus_valid, bus_op, bus_addr, read_done, read_shared,
           send_abort, all_inv_done, done
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1 and
// returns a one-hot selection (all zero when nobody requests).
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N_REQ-1:0] sel
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = IDX_W'((int'(last_grant) + k) % N_REQ);
      if (!found && req[idx]) begin
        sel[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoopy bus arbiter: grants one controller at a time and walks its
// transaction through broadcast, snoop, memory read, invalidate or write-back.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  snoop_bus_arbiter_if.master bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = cnt_width(READ_LAT);

  state_t            state_reg, state_next;
  logic [N_REQ-1:0]  sel_reg, arb_sel, others, pend_reg;
  logic [IDX_W-1:0]  last_grant_reg, sel_idx;
  logic [1:0]        op_reg, pick_op;
  logic [ADDR_W-1:0] addr_reg, pick_addr;
  logic [CNT_W-1:0]  cnt_reg;
  logic              shr_reg, snoop_hit_mod, last_beat, inv_clear;
  logic [1:0]        op_arr   [N_REQ];
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi]   = bus.req_op[2*gi +: 2];
      assign addr_arr[gi] = bus.req_addr[ADDR_W*gi +: ADDR_W];
    end
  endgenerate

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req        (bus.req),
    .last_grant (last_grant_reg),
    .sel        (arb_sel)
  );

  always_comb begin
    pick_op   = '0;
    pick_addr = '0;
    sel_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_sel[i]) begin
        pick_op   = op_arr[i];
        pick_addr = addr_arr[i];
      end
      if (sel_reg[i]) sel_idx = IDX_W'(i);
    end
  end

  // The granted controller never snoops or acks its own transaction.
  assign others        = ~sel_reg;
  assign snoop_hit_mod = |(bus.snoop_mod & others);
  assign last_beat     = (cnt_reg == CNT_W'(1));
  assign inv_clear     = (pend_reg == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel_reg        <= '0;
      last_grant_reg <= IDX_W'(N_REQ - 1);
      op_reg         <= '0;
      addr_reg       <= '0;
      shr_reg        <= 1'b0;
      cnt_reg        <= '0;
      pend_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: if (|bus.req) begin
          sel_reg  <= arb_sel;
          op_reg   <= pick_op;
          addr_reg <= pick_addr;
        end
        SNOOP: begin
          shr_reg  <= |(bus.snoop_shr & others);
          cnt_reg  <= CNT_W'(READ_LAT);
          pend_reg <= others;
        end
        DATA: begin
          cnt_reg  <= cnt_reg - CNT_W'(1);
          pend_reg <= others;
        end
        INV:     pend_reg <= pend_reg & ~bus.inv_ack;
        DONE:    last_grant_reg <= sel_idx;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (|bus.req) state_next = ADDR;
      ADDR:  state_next = SNOOP;
      SNOOP: begin
        if (snoop_hit_mod) state_next = WB;
        else begin
          case (op_reg)
            OP_READ, OP_WMISS: state_next = DATA;
            OP_UPGRADE:        state_next = INV;
            default:           state_next = DONE;
          endcase
        end
      end
      DATA:    if (last_beat) state_next = (op_reg == OP_WMISS) ? INV : DONE;
      INV:     if (inv_clear) state_next = DONE;
      WB:      if (bus.write_back_done) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.grant        = (state_reg == IDLE) ? '0 : sel_reg;
    bus.bus_valid    = (state_reg == ADDR);
    bus.bus_op       = op_reg;
    bus.bus_addr     = addr_reg;
    bus.read_done    = (state_reg == DATA) && last_beat;
    bus.read_shared  = (state_reg == DATA) && last_beat && (op_reg == OP_READ) && shr_reg;
    bus.send_abort   = (state_reg == WB);
    bus.all_inv_done = (state_reg == INV) && inv_clear;
    bus.done         = (state_reg == DONE);
  end

endmodule
